// File: rtl/g_register_mp_pkg.sv
// ---------------------------------------------------------------------------
// g_register_mp_pkg
// Shared parameters for the multi-port general register file and its
// pending-write scoreboard, plus a small helper that tells whether a register
// number names a real, writable register.
// ---------------------------------------------------------------------------
package g_register_mp_pkg;

    localparam int WORD_DEF   = 32;  // data width
    localparam int W_RD_DEF   = 5;   // register number width
    localparam int NREG_DEF   = 32;  // number of registers
    localparam int NRD_DEF    = 2;   // read ports
    localparam int NWB_DEF    = 2;   // write-back ports
    localparam int W_PEND_DEF = 2;   // pending counter width

    // True when num is inside the file and is not the hard-wired zero register.
    function automatic logic reg_live(input int num, input int nreg, input bit zero_r0);
        return (num >= 0) && (num < nreg) && !(zero_r0 && (num == 0));
    endfunction

endpackage

// File: rtl/g_register_sb_entry.sv
// ---------------------------------------------------------------------------
// g_register_sb_entry
// One register's pending-write counter: up by one per accepted reserve, down
// by the number of same-cycle write-backs, clamped to [0, 2^W_PEND-1].
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   inc_i        accepted reserve for this register
//   dec_i        number of write-backs hitting this register this cycle
//   count_o      current pending count
//   full_o       count is at its maximum (further reserves must be refused)
//   underflow_o  more write-backs than outstanding reservations
// ---------------------------------------------------------------------------
module g_register_sb_entry #(
    parameter int W_PEND = 2,
    parameter int W_DEC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic [W_DEC-1:0]  dec_i,
    output logic [W_PEND-1:0] count_o,
    output logic              full_o,
    output logic              underflow_o
);

    // One spare bit so count+1 can exceed the maximum before clamping.
    localparam int W_S = ((W_PEND > W_DEC) ? W_PEND : W_DEC) + 1;
    localparam logic [W_S-1:0] MAX_S = W_S'((32'd1 << W_PEND) - 32'd1);

    logic [W_PEND-1:0] count_q;
    logic [W_PEND-1:0] count_d;
    logic [W_S-1:0]    up_s;
    logic [W_S-1:0]    dec_s;

    // Next count: add the reserve, subtract the write-backs, clamp both ends
    always_comb begin
        up_s  = W_S'(count_q) + W_S'(inc_i);
        dec_s = W_S'(dec_i);
        if (dec_s > up_s) begin
            count_d = '0;
        end else if ((up_s - dec_s) > MAX_S) begin
            count_d = MAX_S[W_PEND-1:0];
        end else begin
            count_d = W_PEND'(up_s - dec_s);
        end
    end

    // Pending count register
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign full_o      = (count_q == MAX_S[W_PEND-1:0]);
    assign underflow_o = (W_S'(dec_i) > W_S'(count_q));

endmodule

// File: rtl/g_register_mp.sv
// ---------------------------------------------------------------------------
// g_register_mp
// Multi-port general register file with a per-register pending-write
// scoreboard. Reads and busy flags are combinational and see same-cycle
// write-back data through a bypass; data, counts and the sticky error flag
// update on the rising edge.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   rsv_i/rsv_num_i          reserve a destination; rsv_ok_o accepts it
//   r_num_i/r_data_o         NRD read ports (packed, port k at k*width)
//   r_busy_o                 register still pending after this cycle's write-backs
//   wb_i/wb_num_i/wb_data_i  NWB independent write-back ports
//   err_o                    sticky: stray, colliding or out-of-range write-back
// ---------------------------------------------------------------------------
module g_register_mp
    import g_register_mp_pkg::*;
#(
    parameter int WORD    = WORD_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int W_RD    = W_RD_DEF,
    parameter int NRD     = NRD_DEF,
    parameter int NWB     = NWB_DEF,
    parameter int W_PEND  = W_PEND_DEF,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rsv_i,
    input  logic [W_RD-1:0]      rsv_num_i,
    output logic                 rsv_ok_o,
    input  logic [NRD*W_RD-1:0]  r_num_i,
    output logic [NRD*WORD-1:0]  r_data_o,
    output logic [NRD-1:0]       r_busy_o,
    input  logic [NWB-1:0]       wb_i,
    input  logic [NWB*W_RD-1:0]  wb_num_i,
    input  logic [NWB*WORD-1:0]  wb_data_i,
    output logic                 err_o
);

    localparam int W_DEC = $clog2(NWB + 1);
    localparam int W_C   = ((W_PEND > W_DEC) ? W_PEND : W_DEC) + 1;

    logic [WORD-1:0]   data_q [NREG];
    logic              err_q;
    logic              err_d;

    logic [W_PEND-1:0] count_s   [NREG];
    logic [W_DEC-1:0]  dec_s     [NREG];
    logic [WORD-1:0]   wr_data_s [NREG];
    logic [NREG-1:0]   wr_en_s;
    logic [NREG-1:0]   inc_s;
    logic [NREG-1:0]   full_s;
    logic [NREG-1:0]   uflow_s;
    logic              wb_err_s;
    logic              rsv_ok_s;

    // Write-back decode: hit count and winning data per register, and
    // error causes that do not depend on the scoreboard
    always_comb begin
        wb_err_s = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            dec_s[i]     = '0;
            wr_en_s[i]   = 1'b0;
            wr_data_s[i] = '0;
        end
        for (int j = 0; j < NWB; j++) begin
            if (wb_i[j]) begin
                if (!(int'(wb_num_i[j*W_RD +: W_RD]) < NREG)) begin
                    wb_err_s = 1'b1;
                end else begin
                    wb_err_s = wb_err_s;
                end
                // Ascending port order lets the highest-index port win.
                for (int i = 0; i < NREG; i++) begin
                    if ((wb_num_i[j*W_RD +: W_RD] == W_RD'(i)) && reg_live(i, NREG, ZERO_R0)) begin
                        dec_s[i]     = dec_s[i] + W_DEC'(1'b1);
                        wr_en_s[i]   = 1'b1;
                        wr_data_s[i] = wb_data_i[j*WORD +: WORD];
                    end else begin
                        wr_en_s[i]   = wr_en_s[i];
                    end
                end
            end else begin
                wb_err_s = wb_err_s;
            end
        end
    end

    // Reserve acceptance; r0 is acknowledged without touching any counter
    always_comb begin
        rsv_ok_s = 1'b0;
        inc_s    = '0;
        if (rst && rsv_i) begin
            if (ZERO_R0 && (rsv_num_i == '0)) begin
                rsv_ok_s = 1'b1;
            end else begin
                for (int i = 0; i < NREG; i++) begin
                    if ((rsv_num_i == W_RD'(i)) && reg_live(i, NREG, ZERO_R0)) begin
                        rsv_ok_s = !full_s[i];
                        inc_s[i] = !full_s[i];
                    end else begin
                        inc_s[i] = inc_s[i];
                    end
                end
            end
        end else begin
            rsv_ok_s = 1'b0;
        end
    end

    assign rsv_ok_o = rsv_ok_s;

    // Per-register pending counters
    for (genvar g = 0; g < NREG; g++) begin : g_sb
        g_register_sb_entry #(
            .W_PEND (W_PEND),
            .W_DEC  (W_DEC)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc_s[g]),
            .dec_i       (dec_s[g]),
            .count_o     (count_s[g]),
            .full_o      (full_s[g]),
            .underflow_o (uflow_s[g])
        );
    end

    // Error accumulation: underflow or more than one port on one register
    always_comb begin
        err_d = err_q | wb_err_s;
        for (int i = 0; i < NREG; i++) begin
            if (uflow_s[i] || (dec_s[i] > W_DEC'(1'b1))) begin
                err_d = 1'b1;
            end else begin
                err_d = err_d;
            end
        end
    end

    // Read ports with same-cycle write-back bypass; busy nets out this
    // cycle's write-backs but ignores this cycle's reserve
    always_comb begin
        r_data_o = '0;
        r_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            for (int i = 0; i < NREG; i++) begin
                if ((r_num_i[k*W_RD +: W_RD] == W_RD'(i)) && reg_live(i, NREG, ZERO_R0)) begin
                    r_data_o[k*WORD +: WORD] = wr_en_s[i] ? wr_data_s[i] : data_q[i];
                    r_busy_o[k]              = (W_C'(count_s[i]) > W_C'(dec_s[i]));
                end else begin
                    r_busy_o[k]              = r_busy_o[k];
                end
            end
        end
    end

    // Register storage and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en_s[i]) begin
                    data_q[i] <= wr_data_s[i];
                end else begin
                    data_q[i] <= data_q[i];
                end
            end
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule
